i2c_txn_sequencer: RTL and testbench

Autonomous transaction sequencer that drives the I2C block's Wishbone slave port in place of the processor. It arbitrates round-robin between two requesters, each asking for a single-byte I2C write or read to a 7-bit device address. For each granted request it issues the fixed register-access program, waits on `irq`, checks the received acknowledge, and returns the read data or an error.

---
 rtl/i2c_txn_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_i2c_txn_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_txn_sequencer.sv
// i2c_txn_sequencer: round-robin I2C transaction engine
// driving the I2C block's Wishbone slave port.
module i2c_txn_sequencer #(
  parameter logic [7:0]  ADR_CTRL     = 8'h02,
  parameter logic [7:0]  ADR_STAT     = 8'h04,
  parameter logic [7:0]  ADR_DATA     = 8'h06,
  parameter logic [7:0]  CTRL_START   = 8'hD0,
  parameter logic [7:0]  CTRL_STOP    = 8'hC0,
  parameter int          STAT_ACK_BIT = 0,
  parameter logic [15:0] TIMEOUT      = 16'd4000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [1:0]  req_i,
  input  logic [1:0]  rw_i,
  input  logic [13:0] dev_i,
  input  logic [15:0] wdata_i,
  output logic [1:0]  gnt_o,
  output logic [1:0]  done_o,
  output logic        err_o,
  output logic [7:0]  rdata_o,
  output logic [7:0]  wb_adr_o,
  output logic [7:0]  wb_dat_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic [7:0]  wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        irq
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_START, S_WAIT1, S_STAT1,
    S_TXD, S_WAIT2, S_STAT2, S_RXD, S_STOP, S_DONE
  } state_t;

  state_t      state, nx;
  logic        go, ph, pri, rw_q, err_q;
  logic [6:0]  dev_q;
  logic [7:0]  wd_q, rd_q;
  logic [15:0] cnt;
  logic        win, is_wait, to_hit;
  logic        a_rw;
  logic [6:0]  a_dev;
  logic [7:0]  a_wd;

  function automatic logic is_bus(state_t s);
    return (s == S_ADDR) || (s == S_START) ||
           (s == S_STAT1) || (s == S_TXD) ||
           (s == S_STAT2) || (s == S_RXD) ||
           (s == S_STOP);
  endfunction

  function automatic logic [7:0] acc_adr(state_t s);
    case (s)
      S_START, S_STOP:       return ADR_CTRL;
      S_STAT1, S_STAT2:      return ADR_STAT;
      S_ADDR, S_TXD, S_RXD:  return ADR_DATA;
      default:               return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] acc_dat(
    state_t s, logic [6:0] d, logic r, logic [7:0] w
  );
    case (s)
      S_ADDR:  return {d, r};
      S_START: return CTRL_START;
      S_TXD:   return w;
      S_STOP:  return CTRL_STOP;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic acc_we(state_t s);
    return (s == S_ADDR) || (s == S_START) ||
           (s == S_TXD) || (s == S_STOP);
  endfunction

  // Winner selection and operand mux (live inputs at grant).
  always_comb begin
    win   = (&req_i) ? pri : req_i[1];
    a_rw  = rw_q;
    a_dev = dev_q;
    a_wd  = wd_q;
    if (state == S_IDLE) begin
      a_rw  = rw_i[win];
      a_dev = win ? dev_i[13:7] : dev_i[6:0];
      a_wd  = win ? wdata_i[15:8] : wdata_i[7:0];
    end
  end

  // Next-state program; ph marks the idle cycle after an ack.
  always_comb begin
    nx      = state;
    go      = 1'b0;
    is_wait = (state == S_WAIT1) || (state == S_WAIT2);
    to_hit  = (cnt == TIMEOUT - 16'd1);
    case (state)
      S_IDLE:  begin go = |req_i; nx = S_ADDR; end
      S_ADDR:  begin go = ph; nx = S_START; end
      S_START: begin go = ph; nx = S_WAIT1; end
      S_WAIT1: begin
        go = irq | to_hit;
        nx = irq ? S_STAT1 : S_STOP;
      end
      S_STAT1: begin
        go = ph;
        nx = err_q ? S_STOP : (rw_q ? S_WAIT2 : S_TXD);
      end
      S_TXD:   begin go = ph; nx = S_WAIT2; end
      S_WAIT2: begin
        go = irq | to_hit;
        nx = irq ? (rw_q ? S_RXD : S_STAT2) : S_STOP;
      end
      S_STAT2: begin go = ph; nx = S_STOP; end
      S_RXD:   begin go = ph; nx = S_STOP; end
      S_STOP:  begin go = ph; nx = S_DONE; end
      S_DONE:  begin go = 1'b1; nx = S_IDLE; end
      default: begin go = 1'b1; nx = S_IDLE; end
    endcase
  end

  // Sequencer state, Wishbone master and requester outputs.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state    <= S_IDLE;
      ph       <= 1'b0;
      pri      <= 1'b0;
      rw_q     <= 1'b0;
      err_q    <= 1'b0;
      dev_q    <= '0;
      wd_q     <= '0;
      rd_q     <= '0;
      cnt      <= '0;
      gnt_o    <= '0;
      done_o   <= '0;
      err_o    <= 1'b0;
      rdata_o  <= '0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_we_o  <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_cyc_o <= 1'b0;
    end else begin
      done_o <= '0;
      if (wb_cyc_o && wb_ack_i) begin
        wb_stb_o <= 1'b0;
        wb_cyc_o <= 1'b0;
        ph       <= 1'b1;
        if (state == S_RXD)
          rd_q <= wb_dat_i;
        if ((state == S_STAT1 || state == S_STAT2) &&
            wb_dat_i[STAT_ACK_BIT])
          err_q <= 1'b1;
      end
      if (is_wait)
        cnt <= cnt + 16'd1;
      if (go) begin
        state <= nx;
        ph    <= 1'b0;
        if (is_bus(nx)) begin
          wb_stb_o <= 1'b1;
          wb_cyc_o <= 1'b1;
          wb_adr_o <= acc_adr(nx);
          wb_dat_o <= acc_dat(nx, a_dev, a_rw, a_wd);
          wb_we_o  <= acc_we(nx);
        end
        if (nx == S_WAIT1 || nx == S_WAIT2)
          cnt <= '0;
        if (is_wait && !irq)
          err_q <= 1'b1;
        case (state)
          S_IDLE: begin
            gnt_o <= win ? 2'b10 : 2'b01;
            pri   <= ~win;
            rw_q  <= a_rw;
            dev_q <= a_dev;
            wd_q  <= a_wd;
            err_q <= 1'b0;
          end
          S_STOP: begin
            done_o  <= gnt_o;
            err_o   <= err_q;
            rdata_o <= (rw_q && !err_q) ? rd_q : 8'h00;
          end
          S_DONE:  gnt_o <= '0;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// tb_i2c_txn_sequencer: random transactions against a
// behavioural I2C slave and a trace-level reference model.
module tb_i2c_txn_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req, rw;
  logic [13:0] dev;
  logic [15:0] wd;
  logic [1:0]  gnt, done;
  logic        err;
  logic [7:0]  rdata, adr, dato, dati;
  logic        we, stb, cyc, ack, irq;

  int total = 0;
  int bad = 0;
  int cyc_n = 0;
  int t_ack = 0;
  int t_stop = 0;
  int last_gnt = 1;

  logic       stb_d = 1'b0;
  logic [1:0] nk = 2'b00;
  logic       irq_en = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic       started, rd_txn;
  int         stat_n;
  int         irq_cnt;

  logic [16:0] trace[$];
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  i2c_txn_sequencer #(.TIMEOUT(16'd100)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .req_i(req), .rw_i(rw), .dev_i(dev), .wdata_i(wd),
    .gnt_o(gnt), .done_o(done), .err_o(err),
    .rdata_o(rdata), .wb_adr_o(adr), .wb_dat_o(dato),
    .wb_we_o(we), .wb_stb_o(stb), .wb_cyc_o(cyc),
    .wb_dat_i(dati), .wb_ack_i(ack), .irq(irq)
  );

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Behavioural I2C block: registered ack, irq 20 cycles
  // after START / data byte, reads clear irq.
  always @(posedge clk) begin
    if (!rst_n) begin
      ack <= 1'b0; irq <= 1'b0; irq_cnt <= 0;
      started <= 1'b0; rd_txn <= 1'b0;
      stat_n <= 0; dati <= 8'h00;
    end else begin
      ack <= stb && cyc && !ack;
      if (irq_cnt != 0) begin
        irq_cnt <= irq_cnt - 1;
        if (irq_cnt == 1) irq <= 1'b1;
      end
      if (stb && cyc && !ack) begin
        if (we) begin
          if (adr == 8'h06) begin
            if (!started) rd_txn <= dato[0];
            else if (irq_en) irq_cnt <= 20;
          end
          if (adr == 8'h02 && dato == 8'hD0) begin
            started <= 1'b1;
            stat_n <= 0;
            if (irq_en) irq_cnt <= 20;
          end
          if (adr == 8'h02 && dato == 8'hC0) begin
            started <= 1'b0;
            irq <= 1'b0;
            irq_cnt <= 0;
          end
        end else begin
          irq <= 1'b0;
          if (adr == 8'h04) begin
            dati <= {7'($urandom),
                     (stat_n == 0) ? nk[0] : nk[1]};
            stat_n <= stat_n + 1;
            if (stat_n == 0 && rd_txn && !nk[0] && irq_en)
              irq_cnt <= 20;
          end else begin
            dati <= rx_byte;
          end
        end
      end
    end
  end

  // Bus monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (stb && cyc && ack) begin
      trace.push_back({we, adr, we ? dato : 8'h00});
      if (we && adr == 8'h02 && dato == 8'hD0)
        t_ack <= cyc_n + 1;
    end
    if (stb && !stb_d && we && adr == 8'h02 && dato == 8'hC0)
      t_stop <= cyc_n;
    stb_d <= stb;
  end

  // Reference: expected bus program from the request alone.
  task automatic build_exp(
    input logic r, input logic [6:0] d, input logic [7:0] w,
    input logic [1:0] k, input logic to, output logic e
  );
    exp_q.delete();
    e = 1'b0;
    exp_q.push_back({1'b1, 8'h06, d, r});
    exp_q.push_back({1'b1, 8'h02, 8'hD0});
    if (to) e = 1'b1;
    else begin
      exp_q.push_back({1'b0, 8'h04, 8'h00});
      if (k[0]) e = 1'b1;
      else if (!r) begin
        exp_q.push_back({1'b1, 8'h06, w});
        exp_q.push_back({1'b0, 8'h04, 8'h00});
        e = k[1];
      end else begin
        exp_q.push_back({1'b0, 8'h06, 8'h00});
      end
    end
    exp_q.push_back({1'b1, 8'h02, 8'hC0});
  endtask

  task automatic run_txn(
    input int n, input logic r, input logic [6:0] d,
    input logic [7:0] w, input logic [1:0] k,
    input logic to, input logic [7:0] rx
  );
    logic e;
    logic [1:0] oh;
    logic [7:0] erd;
    int c;
    int miss;
    oh = (n == 0) ? 2'b01 : 2'b10;
    build_exp(r, d, w, k, to, e);
    erd = (r && !e) ? rx : 8'h00;
    nk = k; irq_en = !to; rx_byte = rx;
    trace.delete();
    rw[n] = r;
    dev[7*n +: 7] = d;
    wd[8*n +: 8] = w;
    req[n] = 1'b1;
    @(negedge clk);
    total++;
    if (gnt !== oh || stb !== 1'b1) begin
      bad++;
      $display("FAIL grant: gnt=%b stb=%b want gnt=%b stb=1",
               gnt, stb, oh);
    end
    rw = 2'($urandom); dev = 14'($urandom); wd = 16'($urandom);
    c = 0;
    while (done === 2'b00 && c < 2000) begin
      @(negedge clk); c++;
    end
    total++;
    if (done !== oh || gnt !== oh) begin
      bad++;
      $display("FAIL done: done=%b gnt=%b want %b", done, gnt, oh);
    end else begin
      total++;
      if (err !== e || rdata !== erd) begin
        bad++;
        $display("FAIL result: err=%b rdata=%h want err=%b rdata=%h",
                 err, rdata, e, erd);
      end
      @(negedge clk);
      total++;
      miss = 0;
      if (trace.size() != exp_q.size()) miss = 1;
      else
        foreach (exp_q[i]) if (trace[i] !== exp_q[i]) miss = 1;
      if (miss != 0) begin
        bad++;
        $display("FAIL trace: got %0d accesses last=%h want %0d last=%h",
                 trace.size(), trace.size() ? trace[$] : 17'h0,
                 exp_q.size(), exp_q[$]);
      end
      total++;
      if (done !== 2'b00 || gnt !== 2'b00) begin
        bad++;
        $display("FAIL pulse: done=%b gnt=%b want 00 00", done, gnt);
      end
    end
    req[n] = 1'b0;
    last_gnt = n;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 2'b00; rw = 2'b00; dev = '0; wd = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({gnt, done, err, rdata, adr, dato, we, stb, cyc} !== '0) begin
      bad++;
      $display("FAIL reset: gnt=%b done=%b err=%b rdata=%h stb=%b want 0",
               gnt, done, err, rdata, stb);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    run_txn(0, 1'b0, 7'h50, 8'hA5, 2'b00, 1'b0, 8'h00);
  endtask

  task automatic test_read();
    run_txn(1, 1'b1, 7'h3C, 8'h00, 2'b00, 1'b0, 8'h5A);
  endtask

  task automatic test_nack();
    run_txn(0, 1'b0, 7'h11, 8'h33, 2'b01, 1'b0, 8'h00);
    run_txn(1, 1'b1, 7'h22, 8'h00, 2'b01, 1'b0, 8'hEE);
    run_txn(0, 1'b0, 7'h44, 8'h55, 2'b10, 1'b0, 8'h00);
  endtask

  task automatic test_timeout();
    run_txn(1, 1'b0, 7'h2A, 8'h77, 2'b00, 1'b1, 8'h00);
    total++;
    if (t_stop - t_ack != 101) begin
      bad++;
      $display("FAIL timeout_gap: stop-ack=%0d want 101",
               t_stop - t_ack);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      logic [1:0] k;
      k[0] = ($urandom_range(0, 3) == 0);
      k[1] = ($urandom_range(0, 3) == 0);
      run_txn(int'($urandom_range(0, 1)), 1'($urandom),
              7'($urandom), 8'($urandom), k,
              ($urandom_range(0, 7) == 0), 8'($urandom));
    end
  endtask

  task automatic test_back_to_back();
    int exp_n;
    int c;
    logic [1:0] oh;
    nk = 2'b00; irq_en = 1'b1;
    rw = 2'b00; dev = 14'($urandom); wd = 16'($urandom);
    req = 2'b11;
    exp_n = 1 - last_gnt;
    for (int t = 0; t < 4; t++) begin
      oh = (exp_n == 0) ? 2'b01 : 2'b10;
      c = 0;
      while (done === 2'b00 && c < 2000) begin
        @(negedge clk); c++;
      end
      total++;
      if (done !== oh || err !== 1'b0) begin
        bad++;
        $display("FAIL b2b_%0d: done=%b err=%b want %b 0",
                 t, done, err, oh);
      end
      if (t == 3) req = 2'b00;
      @(negedge clk);
      exp_n = 1 - exp_n;
    end
    last_gnt = 1 - exp_n;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int c;
    nk = 2'b00; irq_en = 1'b1; rx_byte = 8'h3D;
    rw[0] = 1'b1; dev[6:0] = 7'h19;
    req = 2'b01;
    c = 0;
    while (stat_n != 1 && c < 500) begin
      @(negedge clk); c++;
    end
    total++;
    if (stat_n != 1) begin
      bad++;
      $display("FAIL reach_wait2: stat reads=%0d want 1", stat_n);
    end
    repeat (5) @(negedge clk);
    total++;
    if (gnt !== 2'b01 || irq !== 1'b0) begin
      bad++;
      $display("FAIL in_wait2: gnt=%b irq=%b want 01 0", gnt, irq);
    end
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({gnt, done, err, rdata, adr, dato, we, stb, cyc} !== '0) begin
      bad++;
      $display("FAIL mid_reset: gnt=%b stb=%b cyc=%b adr=%h want 0",
               gnt, stb, cyc, adr);
    end
    req = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    rw = 2'b00;
    req = 2'b11;
    @(negedge clk);
    total++;
    if (gnt !== 2'b01) begin
      bad++;
      $display("FAIL post_reset_gnt: gnt=%b want 01", gnt);
    end
    c = 0;
    while (done === 2'b00 && c < 2000) begin
      @(negedge clk); c++;
    end
    total++;
    if (done !== 2'b01) begin
      bad++;
      $display("FAIL post_reset_done: done=%b want 01", done);
    end
    req = 2'b00;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_nack();
    test_timeout();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
